// File: rtl/delta_distance_if.sv
// delta_distance_if: move-in, distance-lookup and result channels of delta_distance.
// slave is the evaluator side; master is the move generator / distance table / consumer side.
interface delta_distance_if;
   localparam int unsigned OPT_W  = 16;
   localparam int unsigned POS_W  = 7;
   localparam int unsigned DIST_W = 18;
   localparam int unsigned ACC_W  = 21;

   logic              opt_valid;
   logic              opt_ready;
   logic [OPT_W-1:0]  opt;
   logic              dist_req;
   logic [POS_W-1:0]  pos_a;
   logic [POS_W-1:0]  pos_b;
   logic              dist_valid;
   logic [DIST_W-1:0] dist_in;
   logic              delta_valid;
   logic              delta_ready;
   logic [ACC_W-1:0]  delta;
   logic              delta_illegal;

   modport slave (
      input  opt_valid, opt, dist_valid, dist_in, delta_ready,
      output opt_ready, dist_req, pos_a, pos_b, delta_valid, delta, delta_illegal
   );

   modport master (
      output opt_valid, opt, dist_valid, dist_in, delta_ready,
      input  opt_ready, dist_req, pos_a, pos_b, delta_valid, delta, delta_illegal
   );
endinterface

// File: rtl/delta_distance.sv
// delta_distance: tour-length change of one 2-opt / or-opt move from sequenced edge-distance lookups.
// Define DELTA_CHECK_EN to screen illegal moves (no lookups, delta_illegal=1).
module delta_distance #(
   parameter int unsigned CITY_NUM = 30,
   parameter int unsigned DIST_LAT = 2
) (
   input  logic             clk,
   input  logic             reset,
   delta_distance_if.slave  bus
);
   localparam int unsigned POS_W  = 7;
   localparam int unsigned ACC_W  = 21;
   localparam int unsigned IDX_W  = 3;
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(CITY_NUM - 1);

   typedef enum logic [1:0] {CMD_TWO, CMD_OR0, CMD_OR1, CMD_THR} cmd_e;
   typedef enum logic [1:0] {OP_DNOP, OP_ZERO, OP_PLS, OP_MNS} op_e;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

   typedef struct packed {
      cmd_e             cmd;
      logic [POS_W-1:0] k;
      logic [POS_W-1:0] l;
   } opt_t;

   state_e                   r_state, w_state_nxt;
   logic [IDX_W-1:0]         r_idx, w_idx_nxt, w_last_idx;
   opt_t                     r_opt, w_src;
   logic                     w_accept, w_illegal, w_short;
   logic                     w_ret, w_younger_busy, w_last_ret;
   logic                     w_issue_nxt, w_enter_done;
   logic [POS_W-1:0]         w_km1, w_kp1, w_lp1;
   logic [POS_W-1:0]         w_term_a, w_term_b;
   op_e                      w_term_op, w_ret_op;
   op_e                      r_opq [DIST_LAT];
   op_e                      r_req_op;
   logic signed [ACC_W-1:0]  r_acc, w_acc_nxt, w_d;
   logic [ACC_W-1:0]         w_delta_nxt;
   logic                     w_delta_illegal_nxt;

   logic                     r_opt_ready;
   logic                     r_dist_req;
   logic [POS_W-1:0]         r_pos_a, r_pos_b;
   logic                     r_delta_valid;
   logic [ACC_W-1:0]         r_delta;
   logic                     r_delta_illegal;

   assign bus.opt_ready     = r_opt_ready;
   assign bus.dist_req      = r_dist_req;
   assign bus.pos_a         = r_pos_a;
   assign bus.pos_b         = r_pos_b;
   assign bus.delta_valid   = r_delta_valid;
   assign bus.delta         = r_delta;
   assign bus.delta_illegal = r_delta_illegal;

   // In IDLE the terms are steered by the incoming move so the first request leaves on the accept edge.
   assign w_src      = (r_state == S_IDLE) ? opt_t'(bus.opt) : r_opt;
   assign w_accept   = (r_state == S_IDLE) && bus.opt_valid && r_opt_ready;
   assign w_last_idx = (w_src.cmd == CMD_TWO) ? IDX_W'(3) : IDX_W'(5);
   assign w_km1      = (w_src.k == '0) ? LAST_POS : w_src.k - POS_W'(1);
   assign w_kp1      = (w_src.k == LAST_POS) ? '0 : w_src.k + POS_W'(1);
   assign w_lp1      = (w_src.l == LAST_POS) ? '0 : w_src.l + POS_W'(1);

`ifdef DELTA_CHECK_EN
   assign w_illegal = (w_src.cmd != CMD_THR) &&
                      ((w_src.k >= POS_W'(CITY_NUM)) || (w_src.l >= POS_W'(CITY_NUM)) ||
                       ((w_src.cmd != CMD_OR1) && (w_src.k >= w_src.l)) ||
                       ((w_src.cmd == CMD_OR1) &&
                        ({1'b0, w_src.k} <= ({1'b0, w_src.l} + (POS_W+1)'(1)))));
`else
   assign w_illegal = 1'b0;
`endif

   assign w_short    = (w_src.cmd == CMD_THR) || w_illegal;
   assign w_ret_op   = r_opq[DIST_LAT-1];
   assign w_ret      = bus.dist_valid && (w_ret_op != OP_DNOP);
   assign w_last_ret = w_ret && !w_younger_busy;

   // The return in flight is the last one when no younger lookup is still queued.
   always_comb begin
      w_younger_busy = 1'b0;
      for (int i = 0; i < int'(DIST_LAT) - 1; i++) begin
         w_younger_busy = w_younger_busy | (r_opq[i] != OP_DNOP);
      end
   end

   // Lookup term selected by the index of the request about to be issued.
   always_comb begin
      w_term_a  = '0;
      w_term_b  = '0;
      w_term_op = OP_DNOP;
      if (w_src.cmd == CMD_TWO) begin
         case (w_idx_nxt)
            IDX_W'(0): begin w_term_a = w_km1;   w_term_b = w_src.l; w_term_op = OP_ZERO; end
            IDX_W'(1): begin w_term_a = w_src.k; w_term_b = w_lp1;   w_term_op = OP_PLS;  end
            IDX_W'(2): begin w_term_a = w_km1;   w_term_b = w_src.k; w_term_op = OP_MNS;  end
            default:   begin w_term_a = w_src.l; w_term_b = w_lp1;   w_term_op = OP_MNS;  end
         endcase
      end else begin
         case (w_idx_nxt)
            IDX_W'(0): begin w_term_a = w_km1;   w_term_b = w_kp1;   w_term_op = OP_ZERO; end
            IDX_W'(1): begin w_term_a = w_src.l; w_term_b = w_src.k; w_term_op = OP_PLS;  end
            IDX_W'(2): begin w_term_a = w_src.k; w_term_b = w_lp1;   w_term_op = OP_PLS;  end
            IDX_W'(3): begin w_term_a = w_km1;   w_term_b = w_src.k; w_term_op = OP_MNS;  end
            IDX_W'(4): begin w_term_a = w_src.k; w_term_b = w_kp1;   w_term_op = OP_MNS;  end
            default:   begin w_term_a = w_src.l; w_term_b = w_lp1;   w_term_op = OP_MNS;  end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_opt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_accept) r_opt <= w_src;
      end
   end

   // FSM next state; r_idx tracks the request currently on the lookup port.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_idx_nxt   = '0;
               w_state_nxt = w_short ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (r_idx == w_last_idx) w_state_nxt = S_DRAIN;
            else                     w_idx_nxt   = r_idx + IDX_W'(1);
         end
         S_DRAIN: begin
            if (w_last_ret) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (bus.delta_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs and accumulator next values.
   always_comb begin
      w_issue_nxt  = (w_state_nxt == S_ISSUE);
      w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);
      w_d          = $signed(ACC_W'(bus.dist_in));
      w_acc_nxt    = r_acc;
      if (w_ret) begin
         case (w_ret_op)
            OP_ZERO: w_acc_nxt = w_d;
            OP_PLS:  w_acc_nxt = r_acc + w_d;
            OP_MNS:  w_acc_nxt = r_acc - w_d;
            default: w_acc_nxt = r_acc;
         endcase
      end
      w_delta_nxt         = (r_state == S_IDLE) ? '0 : ACC_W'(w_acc_nxt);
      w_delta_illegal_nxt = (r_state == S_IDLE) && w_illegal;
   end

   // Registered outputs, op queue and accumulator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_opt_ready     <= 1'b0;
         r_dist_req      <= 1'b0;
         r_pos_a         <= '0;
         r_pos_b         <= '0;
         r_req_op        <= OP_DNOP;
         for (int i = 0; i < int'(DIST_LAT); i++) r_opq[i] <= OP_DNOP;
         r_acc           <= '0;
         r_delta_valid   <= 1'b0;
         r_delta         <= '0;
         r_delta_illegal <= 1'b0;
      end else begin
         r_opt_ready   <= (w_state_nxt == S_IDLE);
         r_dist_req    <= w_issue_nxt;
         r_pos_a       <= w_issue_nxt ? w_term_a : '0;
         r_pos_b       <= w_issue_nxt ? w_term_b : '0;
         r_req_op      <= w_issue_nxt ? w_term_op : OP_DNOP;
         r_opq[0]      <= r_req_op;
         for (int i = 1; i < int'(DIST_LAT); i++) r_opq[i] <= r_opq[i-1];
         r_acc         <= w_acc_nxt;
         r_delta_valid <= (w_state_nxt == S_DONE);
         if (w_enter_done) begin
            r_delta         <= w_delta_nxt;
            r_delta_illegal <= w_delta_illegal_nxt;
         end
      end
   end
endmodule

// File: doc/delta_distance.md
# delta_distance

Move-cost evaluator for the replica salesman annealer. It sits downstream of the move generator and takes one `opt_t` move: 2-opt or or-opt, with positions K and L. For that move it issues the sequence of tour-edge distance lookups to the route/distance tables and accumulates the signed tour-length change as a `delata_data_t` (3.17). The result goes to the Metropolis/exchange decision stage.

## Interface
- `CITY_NUM`, 30: tour length; positions are 0..CITY_NUM-1.
- `DIST_LAT`, 2: fixed cycles from `dist_req` to the matching `dist_valid`, range 1..4.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `opt_valid` in 1: move offered.
- `opt_ready` out 1: block can accept a move.
- `opt` in 16: `opt_t`, made of {command[1:0], K[6:0], L[6:0]}.
- `dist_req` out 1: distance lookup request.
- `pos_a`, `pos_b` out 7 each: tour positions of the edge endpoints.
- `dist_valid` in 1: distance return strobe.
- `dist_in` in 18: `distance_data_t`, unsigned 1.17.
- `delta_valid` out 1: result available.
- `delta_ready` in 1: consumer accepts the result.
- `delta` out 21: `delata_data_t`, signed 3.17.
- `delta_illegal` out 1: the move failed the legality check; `delta` is 0.

## Operation
- States:
  - IDLE: `opt_ready`=1. On `opt_valid`, latch `opt` and go to ISSUE, or to DONE for THR or an illegal move.
  - ISSUE: one request per cycle for N terms, then go to DRAIN.
  - DRAIN: wait for outstanding returns; go to DONE on the last return.
  - DONE: hold `delta_valid`=1; return to IDLE on `delta_ready`.
- Wrap rules: K-1 is CITY_NUM-1 when K=0. K+1 and L+1 are 0 when the value equals CITY_NUM-1.
- TWO, N=4, terms in order:
  - ZERO (K-1,L)
  - PLS (K,L+1)
  - MNS (K-1,K)
  - MNS (L,L+1)
- OR0 and OR1, moving city K to between L and L+1, N=6, terms in order:
  - ZERO (K-1,K+1)
  - PLS (L,K)
  - PLS (K,L+1)
  - MNS (K-1,K)
  - MNS (K,K+1)
  - MNS (L,L+1)
- THR is not supported: `delta`=0 and `delta_illegal`=0.
- Op queue: a DIST_LAT-deep shift register carries each request's `distance_op_t` so it is aligned with its return.
- Accumulation on `dist_valid`:
  - ZERO: acc = +d.
  - PLS: acc += d.
  - MNS: acc -= d.
  - d is zero-extended to 21 bits; the sum is exact because the 3 positive terms are each < 2, so the total is < 8.
- `dist_valid` arriving while the op queue slot is DNOP is ignored. This includes IDLE and returns after a reset.
- `delta` and `delta_illegal` are registered and stable while `delta_valid`=1.

## Timing
- Reset values: `opt_ready`=0 during reset and 1 after; `dist_req`=0; `pos_a`/`pos_b`=0; `delta_valid`=0; `delta`=0; `delta_illegal`=0. State IDLE; op queue all DNOP.
- Cycle 0 is the accept cycle. Requests are issued on cycles 1..N, and the last return arrives on cycle N+DIST_LAT.
- `delta_valid` rises on cycle N+DIST_LAT+1: 7 cycles for TWO and 9 for OR with DIST_LAT=2.
- THR or illegal moves: `delta_valid` on cycle 1.
- Throughput: one move in flight. `opt_ready`=0 outside IDLE, and there is no accept in the same cycle as `delta_ready`; the next accept is the cycle after return to IDLE.
- Reset mid-operation clears the state, op queue and accumulator immediately. Late `dist_valid` pulses are then ignored.
- Back-pressure: `delta_valid` holds indefinitely while `delta_ready`=0.

## Configuration
- Macro `DELTA_CHECK_EN`.
- With `DELTA_CHECK_EN` defined, an illegal move skips all lookups, gives `delta`=0 and `delta_illegal`=1, with `delta_valid` on cycle 1. Illegal means:
  - TWO with K≥L;
  - OR0 with K≥L;
  - OR1 with K≤L+1;
  - K or L ≥ CITY_NUM.
- Without the macro there is no check: terms are computed literally from K and L, and `delta_illegal` is tied to 0.

## Test plan
- TWO K=3 L=7 with DIST_LAT=2; the bench returns 0x10000, 0x10000, 0x08000, 0x08000.
  - Requests: (2,7), (3,8), (2,3), (7,8) on cycles 1-4.
  - Result: `delta`=0x10000, `delta_valid` on cycle 7.
- OR0 K=2 L=9 returning 0x30000 ×3 and then 0x08000 ×3.
  - Requests: (1,3), (9,2), (2,10), (1,2), (2,3), (9,10).
  - Result: `delta`=+3.75=0x78000 on cycle 9.
- Wrap TWO K=0 L=5: first request is (29,5). Then TWO K=4 L=29: second request is (4,0). All returns 0x04000 gives `delta`=0.
- Illegal OR1 K=5 L=4:
  - With `DELTA_CHECK_EN`: no `dist_req`, `delta`=0, `delta_illegal`=1 on cycle 1.
  - Without it: 6 requests are issued.
- Hold `delta_ready`=0 for 10 cycles: `delta` is stable and `opt_ready`=0. On release, the next move is accepted one cycle later.
- Assert `reset` in cycle 3 of an OR0 move and then inject the stale `dist_valid` pulses. All outputs return to their reset values, and the next TWO move produces the correct `delta`.
